// File: rtl/alu_pkg.sv
// Shared types and default match-table contents for the pipelined logic ALU.
package alu_pkg;

    typedef enum logic {
        GRP_A = 1'b0,
        GRP_B = 1'b1
    } grp_e;

    typedef enum logic [1:0] {
        OPA_AND  = 2'd0,
        OPA_NAND = 2'd1,
        OPA_OR   = 2'd2,
        OPA_XOR  = 2'd3
    } op_a_e;

    typedef enum logic [1:0] {
        OPB_XNOR = 2'd0,
        OPB_AND  = 2'd1,
        OPB_NOR  = 2'd2,
        OPB_OR   = 2'd3
    } op_b_e;

    localparam int unsigned NUM_ENTRIES = 8;

    // Default match values, indexed by {grp, op}.
    localparam logic [7:0] DEF_A_AND  = 8'hFF;
    localparam logic [7:0] DEF_A_NAND = 8'h00;
    localparam logic [7:0] DEF_A_OR   = 8'hF8;
    localparam logic [7:0] DEF_A_XOR  = 8'h83;
    localparam logic [7:0] DEF_B_XNOR = 8'hF1;
    localparam logic [7:0] DEF_B_AND  = 8'hF4;
    localparam logic [7:0] DEF_B_NOR  = 8'hF5;
    localparam logic [7:0] DEF_B_OR   = 8'hFF;

    function automatic logic [7:0] default_match(input logic [2:0] idx);
        logic [7:0] v;
        case (idx)
            3'd0:    v = DEF_A_AND;
            3'd1:    v = DEF_A_NAND;
            3'd2:    v = DEF_A_OR;
            3'd3:    v = DEF_A_XOR;
            3'd4:    v = DEF_B_XNOR;
            3'd5:    v = DEF_B_AND;
            3'd6:    v = DEF_B_NOR;
            default: v = DEF_B_OR;
        endcase
        return v;
    endfunction

    // Zero-extends a default to 64 bits; callers keep the low WIDTH bits,
    // which truncates for WIDTH < 8 and zero-extends for WIDTH > 8.
    function automatic logic [63:0] default_match_wide(input logic [2:0] idx);
        return {56'd0, default_match(idx)};
    endfunction

endpackage

// File: rtl/alu_irq_table.sv
// Runtime-programmable 8-entry match table with a combinational compare port.
// Entries are flops (not RAM) so that reset can restore the defaults.
module alu_irq_table
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             we_i,
    input  logic [2:0]       waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [2:0]       cmp_idx_i,
    input  logic [WIDTH-1:0] cmp_val_i,
    output logic             hit_o
);

    logic [WIDTH-1:0] table_w [NUM_ENTRIES];

    generate
        for (genvar gi = 0; gi < NUM_ENTRIES; gi++) begin : g_entry
            localparam logic [63:0]      RST_WIDE = default_match_wide(3'(gi));
            localparam logic [WIDTH-1:0] RST_VAL  = RST_WIDE[WIDTH-1:0];

            logic [WIDTH-1:0] entry_q;

            // Entry register: default on reset, overwritten by a matching write strobe.
            always_ff @(posedge clk_i or negedge rst_n_i) begin
                if (!rst_n_i) begin
                    entry_q <= RST_VAL;
                end else if (we_i && (waddr_i == 3'(gi))) begin
                    entry_q <= wdata_i;
                end
            end

            assign table_w[gi] = entry_q;
        end
    endgenerate

    // Compare reads the registered value, so a same-cycle write is not yet visible.
    assign hit_o = (table_w[cmp_idx_i] == cmp_val_i);

endmodule

// File: rtl/alu_pipe.sv
// Handshaked two-group logic ALU with a one-deep result register and a
// match-driven sticky interrupt plus saturating event counter.
module alu_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             alu_clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             alu_grp,
    input  logic [1:0]       alu_op,
    input  logic [WIDTH-1:0] alu_in_a,
    input  logic [WIDTH-1:0] alu_in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] alu_out,
    input  logic             alu_irq_en,
    input  logic             alu_irq_clr,
    output logic             alu_irq,
    output logic [CNT_W-1:0] alu_irq_cnt,
    input  logic             cfg_we,
    input  logic [2:0]       cfg_addr,
    input  logic [WIDTH-1:0] cfg_data
);

    logic [WIDTH-1:0] alu_out_q;
    logic             out_valid_q;
    logic             irq_q;
    logic [CNT_W-1:0] irq_cnt_q;

    logic [WIDTH-1:0] result_d;
    logic             xfer;
    logic             table_hit;
    logic             match;

    // Space is available when the output is empty or being drained this cycle.
    assign in_ready = !out_valid_q || out_ready;
    assign xfer     = in_valid && in_ready;

    // Bitwise result for the selected group/opcode.
    always_comb begin
        result_d = '0;
        if (grp_e'(alu_grp) == GRP_A) begin
            case (op_a_e'(alu_op))
                OPA_AND:  result_d = alu_in_a & alu_in_b;
                OPA_NAND: result_d = ~(alu_in_a & alu_in_b);
                OPA_OR:   result_d = alu_in_a | alu_in_b;
                default:  result_d = alu_in_a ^ alu_in_b;
            endcase
        end else begin
            case (op_b_e'(alu_op))
                OPB_XNOR: result_d = ~(alu_in_a ^ alu_in_b);
                OPB_AND:  result_d = alu_in_a & alu_in_b;
                OPB_NOR:  result_d = ~(alu_in_a | alu_in_b);
                default:  result_d = alu_in_a | alu_in_b;
            endcase
        end
    end

    alu_irq_table #(
        .WIDTH (WIDTH)
    ) u_table (
        .clk_i     (alu_clk),
        .rst_n_i   (rst_n),
        .we_i      (cfg_we),
        .waddr_i   (cfg_addr),
        .wdata_i   (cfg_data),
        .cmp_idx_i ({alu_grp, alu_op}),
        .cmp_val_i (result_d),
        .hit_o     (table_hit)
    );

    assign match = xfer && table_hit && alu_irq_en;

    // Result register: load on transfer, empty on an output handshake.
    always_ff @(posedge alu_clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_out_q   <= '0;
            out_valid_q <= 1'b0;
        end else if (xfer) begin
            alu_out_q   <= result_d;
            out_valid_q <= 1'b1;
        end else if (out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    // Sticky interrupt and saturating counter; a match outranks a clear.
    always_ff @(posedge alu_clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_q     <= 1'b0;
            irq_cnt_q <= '0;
        end else if (match) begin
            irq_q <= 1'b1;
            if (alu_irq_clr) begin
                irq_cnt_q <= CNT_W'(1);
            end else if (!(&irq_cnt_q)) begin
                irq_cnt_q <= irq_cnt_q + CNT_W'(1);
            end
        end else if (alu_irq_clr) begin
            irq_q     <= 1'b0;
            irq_cnt_q <= '0;
        end
    end

    assign alu_out     = alu_out_q;
    assign out_valid   = out_valid_q;
    assign alu_irq     = irq_q;
    assign alu_irq_cnt = irq_cnt_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Directed-vector bench for alu_pipe (WIDTH=8, CNT_W=4).
module tb_alu_pipe;

    logic       alu_clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic       alu_grp;
    logic [1:0] alu_op;
    logic [7:0] alu_in_a;
    logic [7:0] alu_in_b;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] alu_out;
    logic       alu_irq_en;
    logic       alu_irq_clr;
    logic       alu_irq;
    logic [3:0] alu_irq_cnt;
    logic       cfg_we;
    logic [2:0] cfg_addr;
    logic [7:0] cfg_data;

    int vec_cnt = 0;
    int err_cnt = 0;

    alu_pipe #(.WIDTH(8), .CNT_W(4)) dut (
        .alu_clk     (alu_clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .alu_grp     (alu_grp),
        .alu_op      (alu_op),
        .alu_in_a    (alu_in_a),
        .alu_in_b    (alu_in_b),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .alu_out     (alu_out),
        .alu_irq_en  (alu_irq_en),
        .alu_irq_clr (alu_irq_clr),
        .alu_irq     (alu_irq),
        .alu_irq_cnt (alu_irq_cnt),
        .cfg_we      (cfg_we),
        .cfg_addr    (cfg_addr),
        .cfg_data    (cfg_data)
    );

    initial alu_clk = 1'b0;
    always #5 alu_clk = ~alu_clk;

    // Advance one edge; outputs are then sampled 1 time unit after it.
    task automatic tick();
        @(posedge alu_clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic g, input logic [1:0] op,
                         input logic [7:0] a, input logic [7:0] b);
        in_valid = v;
        alu_grp  = g;
        alu_op   = op;
        alu_in_a = a;
        alu_in_b = b;
    endtask

    task automatic clear_irq();
        in_valid    = 1'b0;
        alu_irq_clr = 1'b1;
        tick();
        alu_irq_clr = 1'b0;
    endtask

    task automatic test_reset();
        vec_cnt++;
        if ({out_valid, alu_out, alu_irq, alu_irq_cnt, in_ready} !== {1'b0, 8'h00, 1'b0, 4'h0, 1'b1}) begin
            err_cnt++;
            $display("FAIL reset: ov=%b out=%h irq=%b cnt=%h rdy=%b, want ov=0 out=00 irq=0 cnt=0 rdy=1",
                     out_valid, alu_out, alu_irq, alu_irq_cnt, in_ready);
        end
        $display("reset: ov=%b out=%h irq=%b cnt=%h rdy=%b", out_valid, alu_out, alu_irq, alu_irq_cnt, in_ready);
    endtask

    task automatic test_first_match();
        out_ready  = 1'b1;
        alu_irq_en = 1'b1;
        drive(1'b1, 1'b0, 2'd0, 8'hFF, 8'hFF);
        tick();
        in_valid = 1'b0;
        vec_cnt++;
        if ({alu_out, out_valid, alu_irq, alu_irq_cnt} !== {8'hFF, 1'b1, 1'b1, 4'h1}) begin
            err_cnt++;
            $display("FAIL first_match: out=%h ov=%b irq=%b cnt=%h, want FF 1 1 1", alu_out, out_valid, alu_irq, alu_irq_cnt);
        end
        $display("A/AND FF&FF: out=%h ov=%b irq=%b cnt=%h", alu_out, out_valid, alu_irq, alu_irq_cnt);
        tick();
        vec_cnt++;
        if (out_valid !== 1'b0) begin
            err_cnt++;
            $display("FAIL drain: out_valid=%b, want 0", out_valid);
        end
        $display("drain: ov=%b", out_valid);
        clear_irq();
    endtask

    task automatic test_mask();
        alu_irq_en = 1'b0;
        drive(1'b1, 1'b1, 2'd2, 8'h0A, 8'h00);
        tick();
        in_valid = 1'b0;
        vec_cnt++;
        if ({alu_out, alu_irq, alu_irq_cnt} !== {8'hF5, 1'b0, 4'h0}) begin
            err_cnt++;
            $display("FAIL masked: out=%h irq=%b cnt=%h, want F5 0 0", alu_out, alu_irq, alu_irq_cnt);
        end
        $display("B/NOR masked: out=%h irq=%b cnt=%h", alu_out, alu_irq, alu_irq_cnt);
        alu_irq_en = 1'b1;
        in_valid   = 1'b1;
        tick();
        in_valid = 1'b0;
        vec_cnt++;
        if ({alu_out, alu_irq, alu_irq_cnt} !== {8'hF5, 1'b1, 4'h1}) begin
            err_cnt++;
            $display("FAIL unmasked: out=%h irq=%b cnt=%h, want F5 1 1", alu_out, alu_irq, alu_irq_cnt);
        end
        $display("B/NOR unmasked: out=%h irq=%b cnt=%h", alu_out, alu_irq, alu_irq_cnt);
        clear_irq();
    endtask

    // All eight opcodes back to back with a=CC b=AA; none hits a default entry.
    task automatic test_back_to_back();
        logic [7:0] exp_tab [8];
        exp_tab = '{8'h88, 8'h77, 8'hEE, 8'h66, 8'h99, 8'h88, 8'h11, 8'hEE};
        out_ready  = 1'b1;
        alu_irq_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, i[2], i[1:0], 8'hCC, 8'hAA);
            tick();
            vec_cnt++;
            if ({alu_out, out_valid, in_ready, alu_irq} !== {exp_tab[i], 1'b1, 1'b1, 1'b0}) begin
                err_cnt++;
                $display("FAIL op%0d: out=%h ov=%b rdy=%b irq=%b, want %h 1 1 0",
                         i, alu_out, out_valid, in_ready, alu_irq, exp_tab[i]);
            end
            $display("op %0d: out=%h ov=%b", i, alu_out, out_valid);
        end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        drive(1'b1, 1'b0, 2'd2, 8'h01, 8'h02);
        tick();
        drive(1'b1, 1'b0, 2'd3, 8'h0F, 8'h0F);
        vec_cnt++;
        if ({alu_out, out_valid, in_ready} !== {8'h03, 1'b1, 1'b0}) begin
            err_cnt++;
            $display("FAIL bp_load: out=%h ov=%b rdy=%b, want 03 1 0", alu_out, out_valid, in_ready);
        end
        $display("bp load: out=%h ov=%b rdy=%b", alu_out, out_valid, in_ready);
        tick();
        vec_cnt++;
        if ({alu_out, out_valid, in_ready} !== {8'h03, 1'b1, 1'b0}) begin
            err_cnt++;
            $display("FAIL bp_stall: out=%h ov=%b rdy=%b, want 03 1 0", alu_out, out_valid, in_ready);
        end
        $display("bp stall: out=%h ov=%b rdy=%b", alu_out, out_valid, in_ready);
        out_ready = 1'b1;
        #1;
        vec_cnt++;
        if (in_ready !== 1'b1) begin
            err_cnt++;
            $display("FAIL bp_ready: in_ready=%b, want 1", in_ready);
        end
        tick();
        in_valid = 1'b0;
        vec_cnt++;
        if ({alu_out, out_valid} !== {8'h00, 1'b1}) begin
            err_cnt++;
            $display("FAIL bp_release: out=%h ov=%b, want 00 1", alu_out, out_valid);
        end
        $display("bp release: out=%h ov=%b", alu_out, out_valid);
        tick();
        vec_cnt++;
        if (out_valid !== 1'b0) begin
            err_cnt++;
            $display("FAIL bp_empty: ov=%b, want 0 (transfer duplicated)", out_valid);
        end
        $display("bp empty: ov=%b", out_valid);
    endtask

    task automatic test_saturate();
        out_ready  = 1'b1;
        alu_irq_en = 1'b1;
        drive(1'b1, 1'b0, 2'd0, 8'hFF, 8'hFF);
        for (int i = 0; i < 16; i++) tick();
        in_valid = 1'b0;
        vec_cnt++;
        if ({alu_irq, alu_irq_cnt} !== {1'b1, 4'hF}) begin
            err_cnt++;
            $display("FAIL saturate: irq=%b cnt=%h, want 1 F", alu_irq, alu_irq_cnt);
        end
        $display("16 matches: irq=%b cnt=%h", alu_irq, alu_irq_cnt);
        clear_irq();
        vec_cnt++;
        if ({alu_irq, alu_irq_cnt} !== {1'b0, 4'h0}) begin
            err_cnt++;
            $display("FAIL clear: irq=%b cnt=%h, want 0 0", alu_irq, alu_irq_cnt);
        end
        $display("clear: irq=%b cnt=%h", alu_irq, alu_irq_cnt);
        in_valid = 1'b1;
        tick();
        tick();
        alu_irq_clr = 1'b1;
        tick();
        alu_irq_clr = 1'b0;
        in_valid    = 1'b0;
        vec_cnt++;
        if ({alu_irq, alu_irq_cnt} !== {1'b1, 4'h1}) begin
            err_cnt++;
            $display("FAIL clear_vs_match: irq=%b cnt=%h, want 1 1", alu_irq, alu_irq_cnt);
        end
        $display("clear+match: irq=%b cnt=%h", alu_irq, alu_irq_cnt);
        clear_irq();
    endtask

    task automatic test_cfg_write();
        out_ready  = 1'b1;
        alu_irq_en = 1'b1;
        // Write and compare the same entry together: the old 83 still applies.
        cfg_we   = 1'b1;
        cfg_addr = 3'b011;
        cfg_data = 8'h5A;
        drive(1'b1, 1'b0, 2'd3, 8'h80, 8'h03);
        tick();
        cfg_we   = 1'b0;
        in_valid = 1'b0;
        vec_cnt++;
        if ({alu_out, alu_irq, alu_irq_cnt} !== {8'h83, 1'b1, 4'h1}) begin
            err_cnt++;
            $display("FAIL cfg_old: out=%h irq=%b cnt=%h, want 83 1 1", alu_out, alu_irq, alu_irq_cnt);
        end
        $display("write+cmp old: out=%h irq=%b", alu_out, alu_irq);
        clear_irq();
        drive(1'b1, 1'b0, 2'd3, 8'h50, 8'h0A);
        tick();
        in_valid = 1'b0;
        vec_cnt++;
        if ({alu_out, alu_irq} !== {8'h5A, 1'b1}) begin
            err_cnt++;
            $display("FAIL cfg_new: out=%h irq=%b, want 5A 1", alu_out, alu_irq);
        end
        $display("A/XOR 5A: out=%h irq=%b", alu_out, alu_irq);
        clear_irq();
        drive(1'b1, 1'b0, 2'd3, 8'h80, 8'h03);
        tick();
        in_valid = 1'b0;
        vec_cnt++;
        if ({alu_out, alu_irq} !== {8'h83, 1'b0}) begin
            err_cnt++;
            $display("FAIL cfg_stale: out=%h irq=%b, want 83 0", alu_out, alu_irq);
        end
        $display("A/XOR 83 after write: out=%h irq=%b", alu_out, alu_irq);
        tick();
    endtask

    task automatic test_async_reset();
        out_ready  = 1'b0;
        alu_irq_en = 1'b1;
        drive(1'b1, 1'b0, 2'd0, 8'hFF, 8'hFF);
        tick();
        in_valid = 1'b0;
        vec_cnt++;
        if ({out_valid, alu_irq} !== {1'b1, 1'b1}) begin
            err_cnt++;
            $display("FAIL pre_reset: ov=%b irq=%b, want 1 1", out_valid, alu_irq);
        end
        #2;
        rst_n = 1'b0;
        #1;
        vec_cnt++;
        if ({out_valid, alu_out, alu_irq, alu_irq_cnt} !== {1'b0, 8'h00, 1'b0, 4'h0}) begin
            err_cnt++;
            $display("FAIL async_reset: ov=%b out=%h irq=%b cnt=%h, want 0 00 0 0",
                     out_valid, alu_out, alu_irq, alu_irq_cnt);
        end
        $display("async reset: ov=%b out=%h irq=%b cnt=%h", out_valid, alu_out, alu_irq, alu_irq_cnt);
        tick();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        drive(1'b1, 1'b0, 2'd3, 8'h80, 8'h03);
        tick();
        in_valid = 1'b0;
        vec_cnt++;
        if ({alu_out, alu_irq, alu_irq_cnt} !== {8'h83, 1'b1, 4'h1}) begin
            err_cnt++;
            $display("FAIL table_default: out=%h irq=%b cnt=%h, want 83 1 1", alu_out, alu_irq, alu_irq_cnt);
        end
        $display("table restored: out=%h irq=%b cnt=%h", alu_out, alu_irq, alu_irq_cnt);
    endtask

    initial begin
        rst_n       = 1'b0;
        out_ready   = 1'b0;
        alu_irq_en  = 1'b0;
        alu_irq_clr = 1'b0;
        cfg_we      = 1'b0;
        cfg_addr    = 3'd0;
        cfg_data    = 8'h00;
        drive(1'b0, 1'b0, 2'd0, 8'h00, 8'h00);
        tick();
        tick();
        test_reset();
        rst_n = 1'b1;
        test_first_match();
        test_mask();
        test_back_to_back();
        test_backpressure();
        test_saturate();
        test_cfg_write();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/alu_pipe.md
# alu_pipe

Parametrised, handshaked successor to the team's two-group logic ALU. It accepts one operation per transfer on a valid/ready input and computes a WIDTH-bit logic result from group A or group B opcodes. The result goes into a one-deep output register with valid/ready backpressure. Each result is checked against a runtime-programmable match table, and a match raises a sticky, maskable interrupt with a saturating event counter. It sits between the datapath issue logic and the interrupt controller.

## Interface
Clock and reset: one clock; reset is asynchronous and active-low.

Parameters:
- WIDTH, 8, operand/result width (≥4)
- CNT_W, 4, interrupt event counter width

Ports:
- alu_clk  in  1  clock
- rst_n  in  1  async active-low reset
- in_valid  in  1  operation offered
- in_ready  out  1  operation accepted when in_valid&&in_ready
- alu_grp  in  1  0 = group A, 1 = group B
- alu_op  in  2  opcode within group
- alu_in_a, alu_in_b  in  WIDTH  operands
- out_valid  out  1  alu_out holds an unconsumed result
- out_ready  in  1  consumer takes result when out_valid&&out_ready
- alu_out  out  WIDTH  result
- alu_irq_en  in  1  interrupt mask (1 = enabled)
- alu_irq_clr  in  1  single-cycle clear of alu_irq and alu_irq_cnt
- alu_irq  out  1  sticky interrupt
- alu_irq_cnt  out  CNT_W  saturating count of matches
- cfg_we  in  1  match-table write strobe
- cfg_addr  in  3  {grp, op} entry index
- cfg_data  in  WIDTH  match value

## Operation
- Group A ops: 0 AND, 1 NAND, 2 OR, 3 XOR. Group B ops: 0 XNOR, 1 AND, 2 NOR, 3 OR. All are bitwise over WIDTH bits.
- in_ready = !out_valid || out_ready. This is combinational; there is no path from in_valid to in_ready.
- On transfer, alu_out is loaded with the result of the current operands. out_valid is set and the result is never stale.
- out_valid clears on an output handshake unless a new transfer occurs in the same cycle.
- Match table: 8 entries of WIDTH bits, indexed by {grp,op}.
  - Reset values, truncated or zero-extended to WIDTH: A = FF, 00, F8, 83; B = F1, F4, F5, FF.
  - cfg_we writes cfg_data at the next edge.
  - A compare in the same cycle as a write to the same entry uses the old value.
- A match occurs when a transfer's result equals table[{grp,op}] and alu_irq_en=1.
  - On a match, alu_irq is set to 1 at the same edge that loads alu_out.
  - On a match, alu_irq_cnt increments and saturates at all-ones.
- alu_irq_clr=1 clears alu_irq and alu_irq_cnt. If clear and a match fall on the same edge, the match wins: alu_irq=1 and alu_irq_cnt=1.
- An unmasked match while alu_irq is already 1 keeps alu_irq at 1 and still counts.

## Timing
- Reset values: alu_out=0, out_valid=0, alu_irq=0, alu_irq_cnt=0. in_ready=1 while out_valid=0. The table is restored to its defaults.
- Latency is 1 cycle from the transfer edge to out_valid/alu_out/alu_irq.
- Throughput is 1 per cycle while out_ready=1.
- With out_ready=0, alu_out and out_valid hold and in_ready=0. No transfer is lost or duplicated.
- Reset asserted mid-operation: all state clears immediately (async), and any pending result is discarded.
- Reset deassertion is synchronised by the integrator. The first transfer accepted is on the first edge after release.

## Structure
- Package alu_pkg holds:
  - grp_e (GRP_A, GRP_B)
  - op_a_e, op_b_e opcode enums
  - the 8 default match constants as 8-bit localparams, with a width-adapt function
- Sub-module alu_irq_table holds the 8-entry register file, the write port, the compare output and the default reset load. The top level owns the handshake, result register, sticky IRQ and counter.

## Test plan
All scenarios use WIDTH=8, CNT_W=4.
1. Reset, then A/AND a=FF b=FF with out_ready=1 → next cycle alu_out=FF, out_valid=1, alu_irq=1, alu_irq_cnt=1.
2. B/NOR a=0A b=00 (result F5) with alu_irq_en=0 → alu_out=F5, alu_irq=0, alu_irq_cnt=0. Repeat with en=1 → alu_irq=1.
3. Backpressure:
   - out_ready=0, send A/OR 01|02 → alu_out=03, in_ready=0.
   - Offer A/XOR 0F^0F; it must stall.
   - Raise out_ready → 03 is consumed, 00 is accepted, and next cycle alu_out=00.
4. Drive 16 unmasked matches, then clear:
   - alu_irq_cnt saturates at F.
   - alu_irq_clr alone → irq=0, cnt=0.
   - Clear together with a match → irq=1, cnt=1.
5. Write cfg_addr=3'b011 (A/XOR) with 5A, then A/XOR a=50 b=0A → alu_irq=1. The old default value 83 no longer matches.
6. Assert rst_n low while out_valid=1 and alu_irq=1 → out_valid, alu_irq, alu_out and cnt read 0 before the next clock edge, and the table returns to its defaults.
